// File: rtl/vector_execute_skid_buffer.sv
// Two-entry skid buffer placed after the 8-lane vector ALU.
// It holds up to two results with their flags and writeback tag, and hands
// them to writeback over a valid/ready handshake. in_ready comes straight from
// a flop, so there is no combinational path from out_ready back to the ALU.
// Lane-flag summaries are derived from the head entry. A saturating counter
// records the cycles in which downstream holds the head entry back.
module vector_execute_skid_buffer #(
   parameter int V  = 256,
   parameter int F  = 32,
   parameter int RA = 4,
   parameter int SW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [V-1:0]  in_result,
   input  logic [F-1:0]  in_flags,
   input  logic [RA-1:0] in_rd,
   input  logic          in_we,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [V-1:0]  out_result,
   output logic [F-1:0]  out_flags,
   output logic [RA-1:0] out_rd,
   output logic          out_we,
   output logic          out_all_zero,
   output logic          out_any_neg,
   output logic [1:0]    occupancy,
   output logic [SW-1:0] stall_count
);

   // Each lane packs four flags: bit3 N, bit2 Z, bit1 C, bit0 V.
   localparam int LANES = F / 4;

   // The state encoding is the entry count, so occupancy can be driven
   // straight from the state register.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t         state_reg;
   state_t         state_next;
   logic           in_ready_reg;
   logic           in_ready_next;

   // The head entry drives out_*. The skid entry catches the single
   // result that arrives while the head is stalled.
   logic [V-1:0]   head_result_reg;
   logic [F-1:0]   head_flags_reg;
   logic [RA-1:0]  head_rd_reg;
   logic           head_we_reg;
   logic [V-1:0]   skid_result_reg;
   logic [F-1:0]   skid_flags_reg;
   logic [RA-1:0]  skid_rd_reg;
   logic           skid_we_reg;

   logic [SW-1:0]  stall_count_reg;

   logic           valid_int;
   logic           push;
   logic           pop;
   logic           load_head_in;
   logic           load_head_skid;
   logic           load_skid;

   logic [LANES-1:0] lane_z;
   logic [LANES-1:0] lane_n;

   assign valid_int = (state_reg != EMPTY);
   assign push      = in_valid & in_ready_reg;
   assign pop       = valid_int & out_ready;

   // Next-state and datapath-load decode. Flush empties the buffer and
   // loads nothing, so any push in the same cycle is dropped.
   always_comb begin
      state_next     = state_reg;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (push) begin
                  state_next   = ONE;
                  load_head_in = 1'b1;
               end
            end
            ONE: begin
               if (push && pop) begin
                  load_head_in = 1'b1;
               end else if (push) begin
                  state_next = TWO;
                  load_skid  = 1'b1;
               end else if (pop) begin
                  state_next = EMPTY;
               end
            end
            TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  state_next     = ONE;
                  load_head_skid = 1'b1;
               end
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
      // The ready register looks ahead one cycle: it accepts whenever the
      // next state still has a free entry.
      in_ready_next = (state_next != TWO);
   end

   // State and registered ready. Reset overrides flush and any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= EMPTY;
         in_ready_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= in_ready_next;
      end
   end

   // Entry storage. Data is not reset because out_* are masked to zero
   // whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (load_head_in) begin
         head_result_reg <= in_result;
         head_flags_reg  <= in_flags;
         head_rd_reg     <= in_rd;
         head_we_reg     <= in_we;
      end else if (load_head_skid) begin
         head_result_reg <= skid_result_reg;
         head_flags_reg  <= skid_flags_reg;
         head_rd_reg     <= skid_rd_reg;
         head_we_reg     <= skid_we_reg;
      end
      if (load_skid) begin
         skid_result_reg <= in_result;
         skid_flags_reg  <= in_flags;
         skid_rd_reg     <= in_rd;
         skid_we_reg     <= in_we;
      end
   end

   // Backpressure counter. It sticks at all-ones and survives a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count_reg <= '0;
      end else if (valid_int && !out_ready && (stall_count_reg != {SW{1'b1}})) begin
         stall_count_reg <= stall_count_reg + 1'b1;
      end
   end

   // Pick out the per-lane Z and N bits from the head flags.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_z[gi] = head_flags_reg[4*gi+2];
         assign lane_n[gi] = head_flags_reg[4*gi+3];
      end
   endgenerate

   assign in_ready     = in_ready_reg;
   assign out_valid    = valid_int;
   assign out_result   = valid_int ? head_result_reg : '0;
   assign out_flags    = valid_int ? head_flags_reg  : '0;
   assign out_rd       = valid_int ? head_rd_reg     : '0;
   assign out_we       = valid_int & head_we_reg;
   assign out_all_zero = valid_int & (&lane_z);
   assign out_any_neg  = valid_int & (|lane_n);
   assign occupancy    = state_reg;
   assign stall_count  = stall_count_reg;

endmodule

// File: tb/tb_vector_execute_skid_buffer.sv
// Bench for the vector execute skid buffer. Directed stimulus pushes each
// accepted entry into a scoreboard queue. An independent monitor pops that
// queue and compares every output handshake.
module tb_vector_execute_skid_buffer;

   localparam int V  = 256;
   localparam int F  = 32;
   localparam int RA = 4;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [V-1:0]  in_result;
   logic [F-1:0]  in_flags;
   logic [RA-1:0] in_rd;
   logic          in_we;
   logic          out_valid;
   logic          out_ready;
   logic [V-1:0]  out_result;
   logic [F-1:0]  out_flags;
   logic [RA-1:0] out_rd;
   logic          out_we;
   logic          out_all_zero;
   logic          out_any_neg;
   logic [1:0]    occupancy;
   logic [SW-1:0] stall_count;

   typedef struct {
      logic [V-1:0]  r;
      logic [F-1:0]  f;
      logic [RA-1:0] rd;
      logic          we;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   pops   = 0;

   vector_execute_skid_buffer #(.V(V), .F(F), .RA(RA), .SW(SW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd), .in_we(in_we),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags), .out_rd(out_rd), .out_we(out_we),
      .out_all_zero(out_all_zero), .out_any_neg(out_any_neg),
      .occupancy(occupancy), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic model_all_zero(input logic [F-1:0] f);
      logic z = 1'b1;
      for (int k = 0; k < F/4; k++) z = z & f[4*k+2];
      return z;
   endfunction

   function automatic logic model_any_neg(input logic [F-1:0] f);
      logic n = 1'b0;
      for (int k = 0; k < F/4; k++) n = n | f[4*k+3];
      return n;
   endfunction

   task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of in_valid. The entry is queued only if the DUT
   // should accept it, which means the registered ready is high and no
   // flush is active.
   task automatic push(input logic [V-1:0] r, input logic [F-1:0] f,
                       input logic [RA-1:0] rd, input logic we);
      exp_t e;
      in_valid  = 1'b1;
      in_result = r;
      in_flags  = f;
      in_rd     = rd;
      in_we     = we;
      if (in_ready && !flush) begin
         e.r = r; e.f = f; e.rd = rd; e.we = we;
         sb.push_back(e);
      end
      tick();
      in_valid  = 1'b0;
      in_result = '0;
      in_flags  = '0;
      in_rd     = '0;
      in_we     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   // Monitor: every output handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected actual=result %0h required=no entry", out_result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            pops++;
            if (out_result !== e.r || out_flags !== e.f || out_rd !== e.rd || out_we !== e.we ||
                out_all_zero !== model_all_zero(e.f) || out_any_neg !== model_any_neg(e.f)) begin
               errors++;
               $display("FAIL pop_data actual=r%0h f%0h rd%0h we%0b z%0b n%0b required=r%0h f%0h rd%0h we%0b z%0b n%0b",
                        out_result, out_flags, out_rd, out_we, out_all_zero, out_any_neg,
                        e.r, e.f, e.rd, e.we, model_all_zero(e.f), model_any_neg(e.f));
            end else begin
               $display("ok   pop rd=%0h flags=%0h result=%0h", out_rd, out_flags, out_result);
            end
         end
      end
   end

   logic [V-1:0] va, vb;
   int occ_max;
   int pops_before;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0;
      in_rd = '0; in_we = 1'b0; out_ready = 1'b0;
      do_reset();

      // Reset state
      chk("rst_occ", occupancy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_stall", stall_count, 0);
      chk("rst_out_result", out_result, 0);

      // Single push, one-cycle latency
      out_ready = 1'b1;
      push({8{32'h00000001}}, 32'h00000000, 4'd3, 1'b1);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_result", out_result, {8{32'h00000001}});
      chk("t1_out_rd", out_rd, 3);
      chk("t1_all_zero", out_all_zero, 0);
      tick();
      chk("t1_drained_valid", out_valid, 0);
      chk("t1_drained_occ", occupancy, 0);

      // Back-to-back pushes under backpressure
      do_reset();
      out_ready = 1'b0;
      va = {8{32'hA0A00001}};
      vb = {8{32'hB0B00002}};
      push(va, 32'h11111111, 4'd5, 1'b1);
      push(vb, 32'h22222222, 4'd6, 1'b0);
      chk("t2_occ_two", occupancy, 2);
      chk("t2_in_ready_low", in_ready, 0);
      chk("t2_head_is_a", out_result, va);
      tick();
      tick();
      // Stalled cycles: the cycle B was pushed, plus two idle ones.
      chk("t2_stall_3", stall_count, 3);
      out_ready = 1'b1;
      tick();
      chk("t2_occ_after_pop", occupancy, 1);
      chk("t2_in_ready_back", in_ready, 1);
      chk("t2_head_is_b", out_result, vb);
      tick();
      chk("t2_occ_empty", occupancy, 0);
      chk("t2_stall_kept", stall_count, 3);
      chk("t2_sb_empty", sb.size(), 0);

      // Streaming: 16 pushes at full rate
      do_reset();
      out_ready = 1'b1;
      occ_max = 0;
      pops_before = pops;
      for (int i = 0; i < 16; i++) begin
         push({8{32'h10000000 + 32'(i)}}, 32'(i) << 4, 4'(i), i[0]);
         if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      end
      tick();
      chk("t3_occ_max", occ_max, 1);
      chk("t3_pop_count", pops - pops_before, 16);
      chk("t3_stall_zero", stall_count, 0);
      chk("t3_sb_empty", sb.size(), 0);

      // Flag summaries
      push({8{32'h0}}, 32'h44444444, 4'd1, 1'b1);
      chk("t4_all_zero_1", out_all_zero, 1);
      chk("t4_any_neg_0", out_any_neg, 0);
      push({8{32'hFFFFFFFF}}, 32'h80000000, 4'd2, 1'b1);
      chk("t4_all_zero_0", out_all_zero, 0);
      chk("t4_any_neg_1", out_any_neg, 1);
      tick();
      chk("t4_sb_empty", sb.size(), 0);

      // Flush while holding two entries, with a push offered
      do_reset();
      out_ready = 1'b0;
      push(va, 32'h33333333, 4'd7, 1'b1);
      push(vb, 32'h55555555, 4'd8, 1'b1);
      flush = 1'b1;
      push({8{32'hC0C0C0C0}}, 32'h66666666, 4'd9, 1'b1);
      flush = 1'b0;
      sb.delete();
      chk("t5_occ", occupancy, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_in_ready", in_ready, 1);
      chk("t5_out_result", out_result, 0);
      chk("t5_stall_kept", stall_count, 2);
      // Flush while holding one entry, with an accepted push offered
      push({8{32'hD0D0D0D0}}, 32'h0, 4'd10, 1'b1);
      flush = 1'b1;
      push({8{32'hE0E0E0E0}}, 32'h0, 4'd11, 1'b1);
      flush = 1'b0;
      sb.delete();
      chk("t5b_occ", occupancy, 0);
      chk("t5b_stall", stall_count, 3);
      tick();
      chk("t5b_still_empty", out_valid, 0);

      // Saturation of the stall counter, then reset from the full state
      do_reset();
      out_ready = 1'b0;
      push(va, 32'h0, 4'd12, 1'b1);
      push(vb, 32'h0, 4'd13, 1'b1);
      repeat (70000) tick();
      chk("t6_stall_sat", stall_count, 16'hFFFF);
      chk("t6_occ_two", occupancy, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      chk("t6_rst_occ", occupancy, 0);
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_in_ready", in_ready, 1);
      chk("t6_rst_stall", stall_count, 0);
      chk("t6_rst_result", out_result, 0);
      chk("t6_rst_flags", out_flags, 0);
      chk("t6_rst_rd", out_rd, 0);
      chk("t6_rst_we", out_we, 0);
      chk("t6_rst_all_zero", out_all_zero, 0);
      chk("t6_rst_any_neg", out_any_neg, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
